// File: rtl/lcd_bus_pkg.sv
// Shared types and constants for the HD44780-style LCD bus engine.
// Holds the FSM state encoding, default bus timing and the common panel command codes.
package lcd_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_P_SETUP,
    ST_P_STROBE,
    ST_P_HOLD,
    ST_DONE
  } lcd_state_e;

  localparam int DEF_T_AS     = 2;
  localparam int DEF_T_EN     = 16;
  localparam int DEF_T_H      = 2;
  localparam int DEF_POLL_BF  = 1;
  localparam int DEF_POLL_MAX = 1024;

  localparam int LCD_BF_BIT = 7;

  localparam logic [7:0] LCD_CMD_CLEAR        = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY        = 8'h06;
  localparam logic [7:0] LCD_CMD_DISPLAY_ON   = 8'h0C;
  localparam logic [7:0] LCD_CMD_FUNC_8BIT_2L = 8'h38;
  localparam logic [7:0] LCD_CMD_DDRAM_LINE2  = 8'hC0;

  function automatic int lcd_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter with a zero flag that times every bus phase.
// A load of N-1 on phase entry makes the zero flag rise in the phase's last cycle.
module lcd_phase_timer #(
  parameter int CW = 5
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at zero so an idle timer never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_ctrl.sv
// Single-transaction engine for an HD44780-style 8-bit LCD bus with read-back
// and optional busy-flag polling after every write.
module lcd_bus_ctrl
  import lcd_bus_pkg::*;
#(
  parameter int T_AS     = DEF_T_AS,
  parameter int T_EN     = DEF_T_EN,
  parameter int T_H      = DEF_T_H,
  parameter int POLL_BF  = DEF_POLL_BF,
  parameter int POLL_MAX = DEF_POLL_MAX
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iRW,
  input  logic       iStart,
  output logic       oDone,
  output logic       oBusy,
  output logic [7:0] oRDATA,
  output logic       oTimeout,
  output logic [7:0] LCD_DATA_O,
  input  logic [7:0] LCD_DATA_I,
  output logic       LCD_DATA_OE,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic       LCD_EN
);

  localparam int TMAX = lcd_max3(T_AS, T_EN, T_H);
  localparam int CW   = $clog2(TMAX + 1);
  localparam int PW   = $clog2(POLL_MAX + 1);

  lcd_state_e    state_q, state_d;
  logic          rs_q, rs_d;
  logic          rw_q, rw_d;
  logic          oe_q, oe_d;
  logic [7:0]    dout_q, dout_d;
  logic          host_rd_q, host_rd_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          tmo_q, tmo_d;
  logic [PW-1:0] poll_q, poll_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          start_prev_q;
  logic          start_blk_q;
  logic          launch;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_zero;

  function automatic logic [CW-1:0] phase_len(input lcd_state_e s);
    case (s)
      ST_SETUP,  ST_P_SETUP:  return CW'(T_AS - 1);
      ST_STROBE, ST_P_STROBE: return CW'(T_EN - 1);
      ST_HOLD,   ST_P_HOLD:   return CW'(T_H - 1);
      default:                return '0;
    endcase
  endfunction

  function automatic logic is_timed(input lcd_state_e s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

  // A level already high when reset releases stays blocked until it drops.
  assign launch = iStart && !start_prev_q && !start_blk_q;

  always_comb begin
    state_d   = state_q;
    rs_d      = rs_q;
    rw_d      = rw_q;
    oe_d      = oe_q;
    dout_d    = dout_q;
    host_rd_d = host_rd_q;
    rdata_d   = rdata_q;
    tmo_d     = tmo_q;
    poll_d    = poll_q;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d   = ST_SETUP;
          rs_d      = iRS;
          rw_d      = iRW;
          oe_d      = !iRW;
          dout_d    = iDATA;
          host_rd_d = iRW;
          tmo_d     = 1'b0;
          poll_d    = '0;
        end
      end
      ST_SETUP: begin
        if (tmr_zero) state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (tmr_zero) begin
          state_d = ST_HOLD;
          if (host_rd_q) rdata_d = LCD_DATA_I;
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          if (!host_rd_q && (POLL_BF != 0)) begin
            state_d = ST_P_SETUP;
            rs_d    = 1'b0;
            rw_d    = 1'b1;
            oe_d    = 1'b0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_P_SETUP: begin
        if (tmr_zero) state_d = ST_P_STROBE;
      end
      ST_P_STROBE: begin
        if (tmr_zero) begin
          state_d = ST_P_HOLD;
          rdata_d = LCD_DATA_I;
        end
      end
      ST_P_HOLD: begin
        if (tmr_zero) begin
          if (!rdata_q[LCD_BF_BIT]) begin
            state_d = ST_DONE;
          end else if ((poll_q + PW'(1)) == PW'(POLL_MAX)) begin
            poll_d  = poll_q + PW'(1);
            tmo_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            poll_d  = poll_q + PW'(1);
            state_d = ST_P_SETUP;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        rs_d    = 1'b0;
        rw_d    = 1'b0;
        oe_d    = 1'b0;
        dout_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe/busy/done are decoded from the next state so they register in step with it.
  always_comb begin
    en_d     = (state_d == ST_STROBE) || (state_d == ST_P_STROBE);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
    tmr_load = (state_d != state_q) && is_timed(state_d);
    tmr_val  = phase_len(state_d);
  end

  lcd_phase_timer #(
    .CW(CW)
  ) u_timer (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .zero_o    (tmr_zero)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q      <= ST_IDLE;
      rs_q         <= 1'b0;
      rw_q         <= 1'b0;
      oe_q         <= 1'b0;
      dout_q       <= '0;
      host_rd_q    <= 1'b0;
      rdata_q      <= '0;
      tmo_q        <= 1'b0;
      poll_q       <= '0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      start_prev_q <= 1'b0;
      start_blk_q  <= iStart;
    end else begin
      state_q      <= state_d;
      rs_q         <= rs_d;
      rw_q         <= rw_d;
      oe_q         <= oe_d;
      dout_q       <= dout_d;
      host_rd_q    <= host_rd_d;
      rdata_q      <= rdata_d;
      tmo_q        <= tmo_d;
      poll_q       <= poll_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      start_prev_q <= iStart;
      start_blk_q  <= start_blk_q && iStart;
    end
  end

  assign oDone       = done_q;
  assign oBusy       = busy_q;
  assign oRDATA      = rdata_q;
  assign oTimeout    = tmo_q;
  assign LCD_DATA_O  = dout_q;
  assign LCD_DATA_OE = oe_q;
  assign LCD_RW      = rw_q;
  assign LCD_RS      = rs_q;
  assign LCD_EN      = en_q;

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Scoreboard bench for lcd_bus_ctrl: one instance without polling, one polling with POLL_MAX=4.
module tb_lcd_bus_ctrl;
  import lcd_bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1, st0, st1, d_rs, d_rw;
  logic [7:0] d_data;
  logic       done0, busy0, tmo0, oe0, lrw0, lrs0, en0;
  logic       done1, busy1, tmo1, oe1, lrw1, lrs1, en1;
  logic [7:0] rdata0, dout0, din0, rdata1, dout1, din1;
  logic [7:0] rd_val0;
  int         busy_polls;
  int         pstr1, str1;
  logic       en1_prev;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  typedef struct {
    int         done_cyc;
    logic [7:0] rdata;
    logic       chk_rd;
    logic       tmo;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  assign din0 = en0 ? rd_val0 : 8'hFF;
  assign din1 = lrs1 ? 8'hA5 : ((pstr1 >= 1 && pstr1 <= busy_polls) ? 8'h80 : 8'h00);

  lcd_bus_ctrl #(.T_AS(2), .T_EN(16), .T_H(2), .POLL_BF(0), .POLL_MAX(1024)) u0 (
    .iCLK(clk), .iRST(rst0), .iDATA(d_data), .iRS(d_rs), .iRW(d_rw), .iStart(st0),
    .oDone(done0), .oBusy(busy0), .oRDATA(rdata0), .oTimeout(tmo0),
    .LCD_DATA_O(dout0), .LCD_DATA_I(din0), .LCD_DATA_OE(oe0),
    .LCD_RW(lrw0), .LCD_RS(lrs0), .LCD_EN(en0)
  );

  lcd_bus_ctrl #(.T_AS(2), .T_EN(16), .T_H(2), .POLL_BF(1), .POLL_MAX(4)) u1 (
    .iCLK(clk), .iRST(rst1), .iDATA(d_data), .iRS(d_rs), .iRW(d_rw), .iStart(st1),
    .oDone(done1), .oBusy(busy1), .oRDATA(rdata1), .oTimeout(tmo1),
    .LCD_DATA_O(dout1), .LCD_DATA_I(din1), .LCD_DATA_OE(oe1),
    .LCD_RW(lrw1), .LCD_RS(lrs1), .LCD_EN(en1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc + 1);
    end
  endtask

  // Completion monitor and poll-strobe counter for the polling instance.
  always @(negedge clk) begin
    if (done0) begin
      check_eq("done0_pending", q0.size() != 0, 1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        check_eq("done0_cycle", cyc + 1, e0.done_cyc);
        check_eq("done0_tmo", tmo0, e0.tmo);
        if (e0.chk_rd) check_eq("done0_rdata", rdata0, e0.rdata);
      end
    end
    if (done1) begin
      check_eq("done1_pending", q1.size() != 0, 1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        check_eq("done1_cycle", cyc + 1, e1.done_cyc);
        check_eq("done1_tmo", tmo1, e1.tmo);
        if (e1.chk_rd) check_eq("done1_rdata", rdata1, e1.rdata);
      end
    end
    if (en1 && !en1_prev) begin
      str1++;
      if (lrw1 && !lrs1) pstr1++;
    end
    en1_prev = en1;
  end

  task automatic launch0(input logic [7:0] d, input logic rs, input logic rw, output int L);
    @(negedge clk);
    d_data = d; d_rs = rs; d_rw = rw; st0 = 1'b1;
    L = cyc + 1;
  endtask

  task automatic launch1(input logic [7:0] d, input logic rs, input logic rw, output int L);
    @(negedge clk);
    d_data = d; d_rs = rs; d_rw = rw; st1 = 1'b1;
    L = cyc + 1;
  endtask

  task automatic drain0(input int budget);
    int n = 0;
    while (q0.size() != 0 && n < budget) begin
      @(negedge clk); #1; n++;
    end
    check_eq("q0_drain", q0.size(), 0);
  endtask

  task automatic drain1(input int budget);
    int n = 0;
    while (q1.size() != 0 && n < budget) begin
      @(negedge clk); #1; n++;
    end
    check_eq("q1_drain", q1.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int L;
    rst0 = 1'b1; rst1 = 1'b1; st0 = 1'b0; st1 = 1'b0;
    d_rs = 1'b0; d_rw = 1'b0; d_data = 8'h00; rd_val0 = 8'h00;
    busy_polls = 0; pstr1 = 0; str1 = 0; en1_prev = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy0", busy0, 0);
    check_eq("rst_en0", en0, 0);
    check_eq("rst_oe0", oe0, 0);
    check_eq("rst_bus0", {done0, tmo0, lrw0, lrs0, rdata0, dout0}, 0);
    check_eq("rst_bus1", {busy1, en1, oe1, done1, tmo1, lrw1, lrs1, rdata1, dout1}, 0);
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (2) @(negedge clk);

    // Write 0x38 without polling, iStart held high across oDone.
    launch0(LCD_CMD_FUNC_8BIT_2L, 1'b0, 1'b0, L);
    q0.push_back(exp_t'{L + 21, 8'h00, 1'b0, 1'b0});
    for (int t = 1; t <= 22; t++) begin
      @(negedge clk);
      if (t <= 20) begin
        check_eq("wr_oe", oe0, 1);
        check_eq("wr_data", dout0, 8'h38);
        check_eq("wr_rwrs", {lrw0, lrs0}, 2'b00);
      end
      check_eq("wr_en", en0, (t >= 3 && t <= 18));
      check_eq("wr_busy", busy0, (t <= 21));
      check_eq("wr_done", done0, (t == 21));
    end
    check_eq("wr_idle_oe", oe0, 0);
    repeat (8) @(negedge clk);
    check_eq("held_no_relaunch", busy0, 0);
    st0 = 1'b0;
    @(negedge clk);

    // Data read with RS=1.
    rd_val0 = 8'h5A;
    launch0(8'h00, 1'b1, 1'b1, L);
    q0.push_back(exp_t'{L + 21, 8'h5A, 1'b1, 1'b0});
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      check_eq("rd_oe", oe0, 0);
      check_eq("rd_rwrs", {lrw0, lrs0}, 2'b11);
    end
    drain0(10);
    st0 = 1'b0;
    @(negedge clk);

    // Second rising edge while a transaction is in flight is ignored.
    launch0(LCD_CMD_DISPLAY_ON, 1'b0, 1'b0, L);
    q0.push_back(exp_t'{L + 21, 8'h00, 1'b0, 1'b0});
    repeat (4) @(negedge clk);
    st0 = 1'b0;
    repeat (4) @(negedge clk);
    st0 = 1'b1;
    drain0(40);
    repeat (10) @(negedge clk);
    check_eq("midedge_no_relaunch", busy0, 0);
    st0 = 1'b0;
    @(negedge clk);
    launch0(LCD_CMD_ENTRY, 1'b0, 1'b0, L);
    q0.push_back(exp_t'{L + 21, 8'h00, 1'b0, 1'b0});
    @(negedge clk);
    check_eq("relaunch_busy", busy0, 1);
    drain0(40);
    st0 = 1'b0;

    // iStart high while reset releases is not a launch.
    @(negedge clk);
    rst0 = 1'b1; st0 = 1'b1;
    repeat (2) @(negedge clk);
    rst0 = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("rst_high_no_launch", busy0, 0);
    st0 = 1'b0;
    @(negedge clk);
    launch0(LCD_CMD_CLEAR, 1'b0, 1'b0, L);
    q0.push_back(exp_t'{L + 21, 8'h00, 1'b0, 1'b0});
    @(negedge clk);
    check_eq("post_rst_launch", busy0, 1);
    drain0(40);
    st0 = 1'b0;
    @(negedge clk);

    // Reset during STROBE abandons the transaction.
    launch0(LCD_CMD_DDRAM_LINE2, 1'b1, 1'b0, L);
    q0.push_back(exp_t'{L + 21, 8'h00, 1'b0, 1'b0});
    repeat (5) @(negedge clk);
    check_eq("pre_rst_en", en0, 1);
    rst0 = 1'b1; st0 = 1'b0;
    @(negedge clk);
    check_eq("midrst_en", en0, 0);
    check_eq("midrst_oe", oe0, 0);
    check_eq("midrst_rdata", rdata0, 0);
    check_eq("midrst_outs", {busy0, done0, tmo0, lrw0, lrs0, dout0}, 0);
    q0.delete();
    rst0 = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("midrst_idle", busy0, 0);

    // Polling: busy for 3 polls, then clear.
    busy_polls = 3; pstr1 = 0; str1 = 0;
    launch1(LCD_CMD_CLEAR, 1'b0, 1'b0, L);
    q1.push_back(exp_t'{L + 21 + 4 * 20, 8'h00, 1'b1, 1'b0});
    drain1(200);
    check_eq("poll_strobes", pstr1, 4);
    check_eq("all_strobes", str1, 5);
    st1 = 1'b0;
    @(negedge clk);

    // Busy flag stuck: timeout after POLL_MAX polls.
    busy_polls = 1000; pstr1 = 0; str1 = 0;
    launch1(LCD_CMD_ENTRY, 1'b0, 1'b0, L);
    q1.push_back(exp_t'{L + 21 + 4 * 20, 8'h80, 1'b1, 1'b1});
    drain1(200);
    check_eq("tmo_poll_strobes", pstr1, 4);
    @(negedge clk);
    check_eq("tmo_sticky", tmo1, 1);
    st1 = 1'b0;
    @(negedge clk);

    // Next launch clears the timeout; a read does not poll.
    pstr1 = 0;
    launch1(8'h00, 1'b1, 1'b1, L);
    q1.push_back(exp_t'{L + 21, 8'hA5, 1'b1, 1'b0});
    @(negedge clk);
    check_eq("tmo_cleared", tmo1, 0);
    check_eq("rd1_oe", oe1, 0);
    drain1(40);
    check_eq("rd1_no_poll", pstr1, 0);
    st1 = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_bus_ctrl.md
# lcd_bus_ctrl

HD44780-style character-LCD bus engine that executes single write or read transactions on the panel's 8-bit parallel bus. It serves the start/done handshake that our LUT-driven LCD sequencers use to issue commands and characters. It adds read-back support: explicit data/status reads, plus optional busy-flag polling after every write. It sits between a sequencer and the LCD pins, and replaces fixed inter-command delays with status-driven completion.

## Interface
- T_AS, 2: cycles RS/RW/data are stable before LCD_EN rises (≥1).
- T_EN, 16: cycles LCD_EN is held high (≥2).
- T_H, 2: cycles RS/RW/data are held after LCD_EN falls (≥1).
- POLL_BF, 1: 1 = every write is followed by busy-flag polling; 0 = no polling.
- POLL_MAX, 1024: maximum busy-flag reads before timeout (≥1).
- iCLK  in  1  clock; all logic on the rising edge.
- iRST  in  1  reset, synchronous, active-high.
- iDATA  in  8  write data, sampled at launch.
- iRS  in  1  register select, sampled at launch.
- iRW  in  1  0 = write, 1 = read; sampled at launch.
- iStart  in  1  request; a transaction launches on its rising edge.
- oDone  out  1  one-cycle pulse when the transaction completes.
- oBusy  out  1  high while a transaction is in flight.
- oRDATA  out  8  data captured by the last read or poll.
- oTimeout  out  1  set with oDone when polling hit POLL_MAX; cleared at the next launch.
- LCD_DATA_O  out  8  bus drive value.
- LCD_DATA_I  in  8  bus input value (synchronised externally).
- LCD_DATA_OE  out  1  1 = drive the bus.
- LCD_RW, LCD_RS, LCD_EN  out  1 each  panel control lines.

## Operation
- States:
  - IDLE;
  - SETUP, STROBE, HOLD for the host transaction;
  - P_SETUP, P_STROBE, P_HOLD for polling;
  - DONE.
- Launch:
  - Occurs in IDLE when iStart=1 and its registered previous value is 0.
  - A level held high does not relaunch.
  - Rising edges outside IDLE are ignored.
  - The previous-value register still tracks iStart during a transaction.
- On launch, iDATA, iRS and iRW are latched, and the engine goes IDLE→SETUP.
- SETUP: drive LCD_RS/LCD_RW; LCD_DATA_OE = !iRW(latched); LCD_EN=0; dwell T_AS cycles, then go to STROBE.
- STROBE: LCD_EN=1 for T_EN cycles. On reads, oRDATA ← LCD_DATA_I in the last STROBE cycle. Then go to HOLD.
- HOLD: LCD_EN=0 with the bus unchanged for T_H cycles. Next state:
  - P_SETUP if the transaction is a write and POLL_BF=1;
  - DONE otherwise.
- Polling:
  - P_* phases reuse the same timing with RS=0, RW=1, OE=0.
  - oRDATA ← LCD_DATA_I in the last P_STROBE cycle.
  - After P_HOLD, if the captured bit 7 is 0, go to DONE.
  - Otherwise increment the poll count. If the count has reached POLL_MAX, set oTimeout and go to DONE; else return to P_SETUP.
- DONE: oDone=1 for one cycle, then return to IDLE. On entering IDLE, OE drops to 0 and RW, RS and LCD_DATA_O return to 0.
- Reads never drive the bus: OE stays 0 for the entire transaction.
- Reset values: state IDLE, all outputs 0 (including OE, EN, oRDATA, oTimeout), poll counter 0, iStart history 0.
- Reset mid-transaction: LCD_EN and OE are 0 from the cycle after iRST is sampled high, and the transaction is abandoned without oDone.
- If iStart is already high when reset releases, it is not a launch; it must drop and rise again.

## Timing
- L = the edge at which the launch is sampled.
- Bus outputs are valid from L+1.
- LCD_EN is high on cycles L+1+T_AS through L+T_AS+T_EN.
- The bus is held through L+T_AS+T_EN+T_H.
- Without polling, oDone is asserted at L+T_AS+T_EN+T_H+1.
- oBusy is high from L+1 through the oDone cycle inclusive.
- Each poll adds exactly T_AS+T_EN+T_H cycles.
- Phase counters are sized to $clog2(max(T_AS,T_EN,T_H)+1); the poll counter is sized to $clog2(POLL_MAX+1). Neither counter ever wraps.
- The earliest relaunch is a rising edge sampled in the cycle after oDone (IDLE).

## Structure
- Package lcd_bus_pkg holds:
  - the state enum;
  - default timing constants;
  - LCD_BF_BIT=7;
  - named HD44780 command constants (CLEAR 8'h01, ENTRY 8'h06, DISPLAY_ON 8'h0C, FUNC_8BIT_2L 8'h38, DDRAM_LINE2 8'hC0).
- One sub-module, lcd_phase_timer, is a loadable down-counter with a zero flag. It is shared by all six timed phases.

## Test plan
- Write, POLL_BF=0, defaults, iDATA=8'h38, iRS=0:
  - L+1..L+20: OE=1, DATA_O=8'h38, RW=0, RS=0;
  - EN high on L+3..L+18;
  - oDone only at L+21;
  - oBusy L+1..L+21.
- Read, iRS=1, LCD_DATA_I=8'h5A during STROBE:
  - OE stays 0, RW=1;
  - oRDATA=8'h5A at oDone.
- Write with POLL_BF=1, bus model returning 8'h80 for 3 polls then 8'h00:
  - exactly 4 poll strobes with RS=0, RW=1;
  - oDone at L+21+4·20;
  - oTimeout=0.
- POLL_MAX=4, busy flag stuck at 1:
  - 4 polls, then oDone with oTimeout=1;
  - oTimeout clears at the next launch.
- iStart held high across oDone, second rising edge mid-transaction, and iStart high when reset releases: no relaunch in any case; the next 0→1 edge in IDLE launches normally.
- iRST asserted during STROBE: EN=0 and OE=0 on the next cycle, no oDone, all outputs at reset values.
